axi_lite_cmd_mst_intf: RTL and testbench
========================================

AXI_LITE_CMD_MST_INTF -- requirements
Module: axi_lite_cmd_mst_intf

Interface
REQ-001 SHALL have parameter AxiAddrWidth, default 32, the AXI-Lite address width.
REQ-002 SHALL have parameter AxiDataWidth, default 32, the AXI-Lite data width; it is a multiple of 8.
REQ-003 SHALL have parameter ErrCntWidth, default 16, the width of the error counter.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit, the sole clock.
REQ-006 SHALL have port rstn, input, 1 bit, the asynchronous active-low reset.
REQ-007 SHALL have port mst, AXI_LITE.Master modport, AXI-Lite initiator toward the interconnect.
REQ-008 SHALL have port req_valid, input, 1 bit, command valid.
REQ-009 SHALL have port req_ready, output, 1 bit, command accepted.
REQ-010 SHALL have port req_write, input, 1 bit; 1 means write, 0 means read.
REQ-011 SHALL have port req_addr, input, AxiAddrWidth bits, target address.
REQ-012 SHALL have port req_wdata, input, AxiDataWidth bits, write data.
REQ-013 SHALL have port req_wstrb, input, AxiDataWidth/8 bits, write strobes.
REQ-014 SHALL have port rsp_valid, output, 1 bit, response valid.
REQ-015 SHALL have port rsp_ready, input, 1 bit, response consumed.
REQ-016 SHALL have port rsp_rdata, output, AxiDataWidth bits, read data; 0 for writes.
REQ-017 SHALL have port rsp_resp, output, 2 bits, the AXI response code.
REQ-018 SHALL have port rsp_write, output, 1 bit, echo of req_write.
REQ-019 SHALL have port err_count, output, ErrCntWidth bits, saturating count of non-OKAY responses.

Function
REQ-020 SHALL implement the FSM states IDLE, WR (AW/W), WR_B, RD_AR, RD_R and RSP, with at most one outstanding transaction.
REQ-021 SHALL drive req_ready = (state==IDLE); a command is accepted on req_valid & req_ready, and all req_* fields are latched into registers.
REQ-022 On a write accept, SHALL go to WR and assert aw_valid and w_valid in the next cycle, driven from the latched addr, data and strb.
REQ-023 In WR, SHALL deassert aw_valid and w_valid independently after their own handshakes; same-cycle or either-order completion are all legal.
REQ-024 When both AW and W are done, SHALL go to WR_B with b_ready=1; the b handshake latches b_resp, rsp_rdata=0, then the FSM goes to RSP.
REQ-025 On a read accept, SHALL go to RD_AR with ar_valid=1 until ar_ready, then to RD_R with r_ready=1; the r handshake latches r_data and r_resp, then the FSM goes to RSP.
REQ-026 SHALL hold aw_valid, w_valid and ar_valid, and their payloads, stable until the handshake, with no dependency on the ready signals.
REQ-027 SHALL hold rsp_valid=1 in RSP, with rsp_* stable, until rsp_ready; the FSM then returns to IDLE.
REQ-028 A new command is not accepted in the same cycle that the RSP handshake completes; back-to-back commands are separated by at least 1 IDLE cycle.
REQ-029 SHALL tie aw_prot and ar_prot to 3'b000.
REQ-030 Against a zero-wait slave, latency SHALL be: accept at cycle 0, addr valid at cycle 1, data/b handshake at cycle 2 (read) or cycle 1/2 (write), rsp_valid at cycle 3.
REQ-031 SHALL increment err_count by 1 when a b or r handshake carries resp != 2'b00.
REQ-032 err_count SHALL saturate at all-ones and never wrap.
REQ-033 A slave that never responds SHALL hold the FSM in its state indefinitely; the block has no timeout.

Reset
REQ-034 On rstn=0, SHALL asynchronously enter IDLE.
REQ-035 On rstn=0, SHALL clear all AXI valid and ready outputs, rsp_valid and err_count.
REQ-036 On rstn=0, SHALL zero rsp_rdata, rsp_resp, rsp_write and the latched command registers.
REQ-037 Reset mid-transaction SHALL abandon the transaction with no response generated; the interconnect is reset together with this block.
REQ-038 The first command SHALL be accepted no earlier than the first clk edge after rstn deasserts.

Structure
REQ-039 SHALL define the FSM state enum and the response constants (OKAY, EXOKAY, SLVERR, DECERR) in a shared package, axi_lite_cmd_pkg.
REQ-040 SHALL be a single module with no sub-module; the saturating counter is inline.

Verification
REQ-041 Read vs. error slave with ReadDataWord=32'hBADCAB1E, addr 0x40 -> rsp_rdata=32'hBADCAB1E, rsp_resp=2'b11, err_count=1.
REQ-042 Write, addr 0x10, data 32'h12345678, strb 4'hF, vs. an OKAY memory; readback -> rsp_rdata=32'h12345678, rsp_resp=0, err_count=0.
REQ-043 Write with aw_ready delayed 3 cycles and w_ready immediate -> w_valid drops after 1 cycle, aw_valid is held 3 cycles, and there is exactly one b handshake.
REQ-044 rsp_ready held low 5 cycles -> rsp_valid and the payload are stable for 5 cycles, and req_ready=0 throughout.
REQ-045 rstn pulsed low while in RD_R -> ar_valid, r_ready and rsp_valid are 0 immediately, and the next read completes normally.
REQ-046 With ErrCntWidth=2, 5 DECERR reads -> err_count sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/axi_lite_cmd_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_pkg
// Shared types for the AXI-Lite command master:
//   state_e      - command FSM states
//   resp_e       - AXI response codes (OKAY, EXOKAY, SLVERR, DECERR)
//   resp_is_err  - true for any response other than OKAY
// ---------------------------------------------------------------------------
package axi_lite_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,   // AW and W in flight, each retired on its own handshake
    WR_B  = 3'd2,
    RD_AR = 3'd3,
    RD_R  = 3'd4,
    RSP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_cmd_mst_intf_if.sv
// ---------------------------------------------------------------------------
// AXI_LITE
// AXI-Lite bus bundle (five channels, no clock/reset inside).
//   Master modport : drives AW/W/AR payload+valid, B/R ready
//   Slave  modport : drives AW/W/AR ready, B/R payload+valid
// ---------------------------------------------------------------------------
interface AXI_LITE #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) ();

  logic [AddrWidth-1:0]   aw_addr;
  logic [2:0]             aw_prot;
  logic                   aw_valid;
  logic                   aw_ready;

  logic [DataWidth-1:0]   w_data;
  logic [DataWidth/8-1:0] w_strb;
  logic                   w_valid;
  logic                   w_ready;

  logic [1:0]             b_resp;
  logic                   b_valid;
  logic                   b_ready;

  logic [AddrWidth-1:0]   ar_addr;
  logic [2:0]             ar_prot;
  logic                   ar_valid;
  logic                   ar_ready;

  logic [DataWidth-1:0]   r_data;
  logic [1:0]             r_resp;
  logic                   r_valid;
  logic                   r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid,    input w_ready,
    input  b_resp, b_valid,            output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input  r_data, r_resp, r_valid,    output r_ready
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid,    output w_ready,
    output b_resp, b_valid,            input b_ready,
    input  ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid,    input r_ready
  );

endinterface

// File: rtl/axi_lite_cmd_mst_intf.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_mst_intf
// Turns a simple valid/ready command into one AXI-Lite read or write and
// returns the result on a valid/ready response port. One transaction at a
// time; counts non-OKAY responses in a saturating counter.
//
// Ports
//   clk, rstn         clock, asynchronous active-low reset
//   mst               AXI_LITE.Master toward the interconnect
//   req_valid/ready   command handshake; req_ready is high only in IDLE
//   req_write/addr/wdata/wstrb  command fields, latched on accept
//   rsp_valid/ready   response handshake
//   rsp_rdata/resp/write        response payload (rdata is 0 for writes)
//   err_count         saturating count of non-OKAY B/R responses
// ---------------------------------------------------------------------------
module axi_lite_cmd_mst_intf
  import axi_lite_cmd_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiDataWidth = 32,
  parameter int unsigned ErrCntWidth  = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  AXI_LITE.Master                   mst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [AxiAddrWidth-1:0]   req_addr,
  input  logic [AxiDataWidth-1:0]   req_wdata,
  input  logic [AxiDataWidth/8-1:0] req_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [AxiDataWidth-1:0]   rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_write,
  output logic [ErrCntWidth-1:0]    err_count
);

  state_e state_q, state_d;

  // Latched command
  logic                      write_q;
  logic [AxiAddrWidth-1:0]   addr_q;
  logic [AxiDataWidth-1:0]   wdata_q;
  logic [AxiDataWidth/8-1:0] wstrb_q;

  // In WR each channel stays pending until its own handshake
  logic aw_pend_q, aw_pend_d;
  logic w_pend_q,  w_pend_d;

  logic [AxiDataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q,  rsp_resp_d;
  logic [ErrCntWidth-1:0]  err_count_q, err_count_d;

  logic cmd_accept;
  logic aw_valid, w_valid;
  logic err_inc;

  // All AXI valids/readies decode only from registered state, so they never
  // depend combinationally on the slave's ready/valid inputs.
  assign req_ready  = (state_q == IDLE);
  assign cmd_accept = req_valid & req_ready;
  assign aw_valid   = (state_q == WR) & aw_pend_q;
  assign w_valid    = (state_q == WR) & w_pend_q;

  assign mst.aw_addr  = addr_q;
  assign mst.aw_prot  = 3'b000;
  assign mst.aw_valid = aw_valid;
  assign mst.w_data   = wdata_q;
  assign mst.w_strb   = wstrb_q;
  assign mst.w_valid  = w_valid;
  assign mst.b_ready  = (state_q == WR_B);
  assign mst.ar_addr  = addr_q;
  assign mst.ar_prot  = 3'b000;
  assign mst.ar_valid = (state_q == RD_AR);
  assign mst.r_ready  = (state_q == RD_R);

  assign rsp_valid = (state_q == RSP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_write = write_q;
  assign err_count = err_count_q;

  always_comb begin
    state_d     = state_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    err_inc     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            state_d   = WR;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end else begin
            state_d = RD_AR;
          end
        end
      end
      WR: begin
        if (aw_valid && mst.aw_ready) aw_pend_d = 1'b0;
        if (w_valid && mst.w_ready)   w_pend_d  = 1'b0;
        // Covers same-cycle completion as well as either order
        if (!aw_pend_d && !w_pend_d)  state_d   = WR_B;
      end
      WR_B: begin
        if (mst.b_valid) begin
          rsp_resp_d  = mst.b_resp;
          rsp_rdata_d = '0;
          err_inc     = resp_is_err(mst.b_resp);
          state_d     = RSP;
        end
      end
      RD_AR: begin
        if (mst.ar_ready) state_d = RD_R;
      end
      RD_R: begin
        if (mst.r_valid) begin
          rsp_resp_d  = mst.r_resp;
          rsp_rdata_d = mst.r_data;
          err_inc     = resp_is_err(mst.r_resp);
          state_d     = RSP;
        end
      end
      RSP: begin
        // Returning to IDLE (not straight to accept) forces one idle cycle
        // between back-to-back commands.
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_count_d = err_count_q;
    if (err_inc && !(&err_count_q)) err_count_d = err_count_q + ErrCntWidth'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      err_count_q <= err_count_d;
      if (cmd_accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_mst_intf.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_cmd_mst_intf
// Randomised bench for axi_lite_cmd_mst_intf. A behavioural AXI-Lite slave
// (per-channel configurable delays, address-decoded error regions) answers
// the DUT; a reference model computes each command's expected response at
// acceptance and queues it; a monitor consumes responses and compares.
//   addr bit 6 set -> DECERR, else bit 7 set -> SLVERR, else OKAY memory.
//   Error reads return 32'hBADCAB1E; error writes leave memory untouched.
// ---------------------------------------------------------------------------
module tb_axi_lite_cmd_mst_intf;
  import axi_lite_cmd_pkg::*;

  localparam int EW = 2;
  localparam int ERR_MAX = (1 << EW) - 1;
  localparam logic [31:0] ERR_WORD = 32'hBADCAB1E;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_write;
  logic [EW-1:0] err_count;

  AXI_LITE #(.AddrWidth(32), .DataWidth(32)) axi ();

  axi_lite_cmd_mst_intf #(
    .AxiAddrWidth(32), .AxiDataWidth(32), .ErrCntWidth(EW)
  ) dut (
    .clk(clk), .rstn(rstn), .mst(axi.Master),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .err_count(err_count)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- environment rules ----------------
  function automatic logic [1:0] region_resp(input logic [31:0] a);
    if (a[6]) return DECERR;
    if (a[7]) return SLVERR;
    return OKAY;
  endfunction

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic          wr;
    logic [31:0]   rdata;
    logic [1:0]    resp;
    logic [EW-1:0] err;
    int            acc_cyc;
    int            lat;
    int            stall;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  int          ref_err = 0;
  int          n_wr = 0;

  // slave configuration for the transaction in flight
  int cfg_aw = 1, cfg_w = 1, cfg_ar = 1, cfg_b = 0, cfg_r = 0;

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int awd, input int wd, input int ard,
                       input int bx, input int rx, input int stall);
    exp_t e;
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data; req_wstrb = strb;
    t = 0;
    while (!req_ready && t < 300) begin @(negedge clk); t++; end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL req_accept: req_ready never rose within 300 cycles, required 1");
      req_valid = 1'b0;
      return;
    end
    // accepted on the coming posedge
    cfg_aw = awd; cfg_w = wd; cfg_ar = ard; cfg_b = bx; cfg_r = rx;
    e.wr = wr;
    e.resp = region_resp(addr);
    if (wr) begin
      e.rdata = '0;
      if (e.resp == OKAY)
        ref_mem[addr] = merge(ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr), data, strb);
      e.lat = ((awd > wd) ? awd : wd) + bx + 2;
      n_wr++;
    end else begin
      e.rdata = (e.resp != OKAY) ? ERR_WORD : (ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr));
      e.lat = ard + rx + 2;
    end
    if (e.resp != OKAY && ref_err < ERR_MAX) ref_err++;
    e.err = EW'(ref_err);
    e.acc_cyc = cyc;
    e.stall = stall;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom); req_write = ~wr;
  endtask

  // ---------------- behavioural AXI-Lite slave ----------------
  logic [31:0] slv_mem [logic [31:0]];
  int n_aw_hs = 0, n_b_hs = 0;
  int aw_cnt, w_cnt, ar_cnt, aw_cyc_l, w_cyc_l, b_wait, r_wait;
  logic got_aw, got_w;
  logic [31:0] aw_addr_l, w_data_l, rd_data_l;
  logic [3:0]  w_strb_l;
  logic [1:0]  b_resp_l, rd_resp_l;
  logic sv_aw_v, sv_w_v, sv_ar_v, sv_b_rdy, sv_r_rdy;
  logic [31:0] sv_aw_addr, sv_ar_addr, sv_w_data;
  logic [3:0]  sv_w_strb;
  logic [2:0]  sv_aw_prot, sv_ar_prot;

  initial begin
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
    axi.b_valid = 1'b0; axi.b_resp = '0; axi.r_valid = 1'b0; axi.r_data = '0; axi.r_resp = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
        axi.b_valid = 1'b0; axi.r_valid = 1'b0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = -1; r_wait = -1;
        got_aw = 1'b0; got_w = 1'b0;
        sv_aw_v = 1'b0; sv_w_v = 1'b0; sv_ar_v = 1'b0; sv_b_rdy = 1'b0; sv_r_rdy = 1'b0;
        continue;
      end
      // handshakes that completed on the posedge just passed
      if (sv_aw_v && axi.aw_ready) begin
        got_aw = 1'b1; aw_addr_l = sv_aw_addr; aw_cyc_l = aw_cnt; aw_cnt = 0; n_aw_hs++;
        chk("aw_prot", 64'(sv_aw_prot), 64'd0);
      end
      if (sv_w_v && axi.w_ready) begin
        got_w = 1'b1; w_data_l = sv_w_data; w_strb_l = sv_w_strb; w_cyc_l = w_cnt; w_cnt = 0;
      end
      if (sv_ar_v && axi.ar_ready) begin
        chk("ar_prot", 64'(sv_ar_prot), 64'd0);
        rd_resp_l = region_resp(sv_ar_addr);
        rd_data_l = (rd_resp_l != OKAY) ? ERR_WORD
                  : (slv_mem.exists(sv_ar_addr) ? slv_mem[sv_ar_addr] : dflt(sv_ar_addr));
        r_wait = cfg_r; ar_cnt = 0;
      end
      if (axi.b_valid && sv_b_rdy) begin axi.b_valid = 1'b0; n_b_hs++; end
      if (axi.r_valid && sv_r_rdy) axi.r_valid = 1'b0;
      if (got_aw && got_w) begin
        got_aw = 1'b0; got_w = 1'b0;
        chk("aw_valid_cycles", 64'(aw_cyc_l), 64'(cfg_aw));
        chk("w_valid_cycles", 64'(w_cyc_l), 64'(cfg_w));
        b_resp_l = region_resp(aw_addr_l);
        if (b_resp_l == OKAY)
          slv_mem[aw_addr_l] = merge(slv_mem.exists(aw_addr_l) ? slv_mem[aw_addr_l]
                                                                : dflt(aw_addr_l), w_data_l, w_strb_l);
        b_wait = cfg_b;
      end
      if (b_wait == 0) begin axi.b_valid = 1'b1; axi.b_resp = b_resp_l; b_wait = -1; end
      else if (b_wait > 0) b_wait--;
      if (r_wait == 0) begin
        axi.r_valid = 1'b1; axi.r_data = rd_data_l; axi.r_resp = rd_resp_l; r_wait = -1;
      end else if (r_wait > 0) r_wait--;
      // address/data channels: payload must hold while waiting for ready
      if (axi.aw_valid) begin
        if (aw_cnt > 0) chk("aw_addr_stable", 64'(axi.aw_addr), 64'(sv_aw_addr));
        aw_cnt++;
      end
      if (axi.w_valid) begin
        if (w_cnt > 0) chk("w_stable", 64'({axi.w_strb, axi.w_data}), 64'({sv_w_strb, sv_w_data}));
        w_cnt++;
      end
      if (axi.ar_valid) begin
        if (ar_cnt > 0) chk("ar_addr_stable", 64'(axi.ar_addr), 64'(sv_ar_addr));
        ar_cnt++;
      end
      axi.aw_ready = axi.aw_valid && (aw_cnt >= cfg_aw);
      axi.w_ready  = axi.w_valid  && (w_cnt  >= cfg_w);
      axi.ar_ready = axi.ar_valid && (ar_cnt >= cfg_ar);
      sv_aw_v = axi.aw_valid; sv_aw_addr = axi.aw_addr; sv_aw_prot = axi.aw_prot;
      sv_w_v = axi.w_valid; sv_w_data = axi.w_data; sv_w_strb = axi.w_strb;
      sv_ar_v = axi.ar_valid; sv_ar_addr = axi.ar_addr; sv_ar_prot = axi.ar_prot;
      sv_b_rdy = axi.b_ready; sv_r_rdy = axi.r_ready;
    end
  end

  // ---------------- response sink / monitor ----------------
  initial begin
    exp_t e;
    int vcyc, first_cyc, stall_t;
    logic sv_v, sv_rdy;
    logic [36:0] sv_pl;
    rsp_ready = 1'b0; vcyc = 0; first_cyc = 0; sv_v = 1'b0; sv_rdy = 1'b0; sv_pl = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin rsp_ready = 1'b0; vcyc = 0; sv_v = 1'b0; sv_rdy = 1'b0; continue; end
      if (sv_v && sv_rdy) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rsp: response %0h with empty scoreboard", sv_pl);
        end else begin
          e = sb_q.pop_front();
          $display("rsp %s rdata=%08h resp=%0d err=%0d lat=%0d hold=%0d",
                   e.wr ? "WR" : "RD", sv_pl[35:4], sv_pl[3:2], sv_pl[1:0], first_cyc - e.acc_cyc, vcyc);
          chk("rsp_write", 64'(sv_pl[36]), 64'(e.wr));
          chk("rsp_rdata", 64'(sv_pl[35:4]), 64'(e.rdata));
          chk("rsp_resp", 64'(sv_pl[3:2]), 64'(e.resp));
          chk("err_count", 64'(sv_pl[1:0]), 64'(e.err));
          chk("latency", 64'(first_cyc - e.acc_cyc), 64'(e.lat));
          chk("rsp_hold_cycles", 64'(vcyc), 64'(e.stall + 1));
        end
        vcyc = 0;
      end
      if (rsp_valid) begin
        if (vcyc > 0) chk("rsp_stable", 64'({rsp_write, rsp_rdata, rsp_resp, err_count}), 64'(sv_pl));
        else first_cyc = cyc;
        chk("req_ready_in_rsp", 64'(req_ready), 64'd0);
        vcyc++;
        stall_t = (sb_q.size() != 0) ? sb_q[0].stall : 0;
        rsp_ready = (vcyc > stall_t);
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
      end
      sv_v = rsp_valid; sv_rdy = rsp_ready;
      sv_pl = {rsp_write, rsp_rdata, rsp_resp, err_count};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    logic [31:0] a;
    int sel;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_valids", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid}), 64'd0);
    chk("reset_readies", 64'({axi.b_ready, axi.r_ready}), 64'd0);
    chk("reset_err_count", 64'(err_count), 64'd0);
    chk("reset_rsp_payload", 64'({rsp_write, rsp_rdata, rsp_resp}), 64'd0);
    rstn = 1'b1;

    // write then read back from the OKAY region
    issue(1'b1, 32'h10, 32'h12345678, 4'hF, 1, 1, 1, 0, 0, 0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1, 1, 1, 0, 0, 0);
    // DECERR reads: err_count 1,2,3,3,3
    issue(1'b0, 32'h40, 32'h0, 4'h0, 1, 1, 1, 0, 0, 0);
    // aw_ready after 3 cycles, w_ready immediate
    issue(1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 3, 1, 1, 0, 0, 0);
    // response held off for 5 cycles
    issue(1'b0, 32'h14, 32'h0, 4'h0, 1, 1, 1, 0, 0, 5);
    for (int i = 0; i < 4; i++) issue(1'b0, 32'h44 + 32'(4 * i), 32'h0, 4'h0, 1, 1, 2, 0, 1, 0);
    // partial-strobe write, W before AW and AW before W
    issue(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 1, 3, 1, 1, 0, 0);
    issue(1'b1, 32'h18, 32'h0BADF00D, 4'hF, 2, 1, 1, 0, 0, 1);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1, 1, 1, 0, 0, 0);

    // reset while waiting in RD_R
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1, 1, 1, 0, 20, 0);
    t = 0;
    while (!axi.r_ready && t < 50) begin @(negedge clk); t++; end
    chk("reached_rd_r", 64'(axi.r_ready), 64'd1);
    rstn = 1'b0;
    #1;
    chk("rst_ar_valid", 64'(axi.ar_valid), 64'd0);
    chk("rst_r_ready", 64'(axi.r_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    sb_q.delete();
    ref_err = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1, 1, 1, 0, 0, 0);

    // randomised traffic
    for (int i = 0; i < 150; i++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      sel = $urandom_range(0, 9);
      if (sel == 0) a = a | 32'h40;
      else if (sel == 1) a = a | 32'h80;
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
            $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    t = 0;
    while (sb_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    chk("aw_handshakes", 64'(n_aw_hs), 64'(n_wr));
    chk("b_handshakes", 64'(n_b_hs), 64'(n_wr));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
